// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshake.
// Stage 1 adds the low half; stage 2 adds the high half with the registered mid carry.
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned NGRP = HALF / GROUP;

  // Returns {carry_out, sum}. Carries inside a group are flat sum-of-products
  // seeded by the group carry-in; group carries ripple into the next group.
  function automatic logic [HALF:0] cla_half(input logic [HALF-1:0] x,
                                             input logic [HALF-1:0] y,
                                             input logic            ci);
    logic [HALF-1:0] g;
    logic [HALF-1:0] p;
    logic [HALF:0]   c;
    logic            prod;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int unsigned grp = 0; grp < NGRP; grp++) begin
      for (int unsigned j = 0; j < GROUP; j++) begin
        prod = c[grp*GROUP];
        for (int unsigned m = 0; m <= j; m++) prod = prod & p[grp*GROUP+m];
        c[grp*GROUP+j+1] = prod;
        for (int unsigned k = 0; k <= j; k++) begin
          prod = g[grp*GROUP+k];
          for (int unsigned m = k + 1; m <= j; m++) prod = prod & p[grp*GROUP+m];
          c[grp*GROUP+j+1] = c[grp*GROUP+j+1] | prod;
        end
      end
    end
    return {c[HALF], p ^ c[HALF-1:0]};
  endfunction

  logic            s1_valid_q, s1_valid_d;
  logic [HALF-1:0] s1_a_hi_q, s1_a_hi_d;
  logic [HALF-1:0] s1_b_hi_q, s1_b_hi_d;
  logic [HALF-1:0] s1_lo_sum_q, s1_lo_sum_d;
  logic            s1_c_mid_q, s1_c_mid_d;
  logic            s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic            adv1, adv2;
  logic [HALF:0]   lo_res, hi_res;

  always_comb begin
    adv2 = !s2_valid_q || out_ready;
    adv1 = !s1_valid_q || adv2;
  end

  always_comb begin
    lo_res      = cla_half(a[HALF-1:0], b[HALF-1:0], cin);
    hi_res      = cla_half(s1_a_hi_q, s1_b_hi_q, s1_c_mid_q);
    s1_valid_d  = s1_valid_q;
    s1_a_hi_d   = s1_a_hi_q;
    s1_b_hi_d   = s1_b_hi_q;
    s1_lo_sum_d = s1_lo_sum_q;
    s1_c_mid_d  = s1_c_mid_q;
    s2_valid_d  = s2_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    if (adv1) begin
      s1_valid_d  = in_valid;
      s1_a_hi_d   = a[WIDTH-1:HALF];
      s1_b_hi_d   = b[WIDTH-1:HALF];
      s1_lo_sum_d = lo_res[HALF-1:0];
      s1_c_mid_d  = lo_res[HALF];
    end
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      sum_d      = {hi_res[HALF-1:0], s1_lo_sum_q};
      cout_d     = hi_res[HALF];
      // carry into the MSB is recovered as a^b^sum at that bit
      ovf_d      = hi_res[HALF] ^ s1_a_hi_q[HALF-1] ^ s1_b_hi_q[HALF-1] ^ hi_res[HALF-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_hi_q   <= '0;
      s1_b_hi_q   <= '0;
      s1_lo_sum_q <= '0;
      s1_c_mid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_hi_q   <= s1_a_hi_d;
      s1_b_hi_q   <= s1_b_hi_d;
      s1_lo_sum_q <= s1_lo_sum_d;
      s1_c_mid_q  <= s1_c_mid_d;
      s2_valid_q  <= s2_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    in_ready  = adv1;
    out_valid = s2_valid_q;
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed vector table, backpressure
// sequence and random streaming against a queue-based scoreboard.
module tb_cla_pipe_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [W+1:0] sbq[$];
  logic         hold_pending = 1'b0;
  logic [W-1:0] held_sum;
  logic         held_cout;
  logic         held_ovf;
  logic         last_acc;
  int           popped = 0;

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    logic [W:0] full;
    logic       o;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    o    = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return {o, full};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: settle, score the handshakes at the coming edge, advance to next negedge.
  task automatic tick();
    logic [W+1:0] e;
    #1;
    last_acc = 1'b0;
    if (rst) begin
      sbq.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        total++;
        if (!(out_valid === 1'b1 && sum === held_sum && cout === held_cout && ovf === held_ovf)) begin
          bad++;
          $display("FAIL hold: got v=%b s=%h c=%b o=%b expected v=1 s=%h c=%b o=%b",
                   out_valid, sum, cout, ovf, held_sum, held_cout, held_ovf);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        popped++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL scoreboard: got unexpected output s=%h expected none", sum);
        end else begin
          e = sbq.pop_front();
          if ({ovf, cout, sum} !== e) begin
            bad++;
            $display("FAIL scoreboard: got o=%b c=%b s=%h expected o=%b c=%b s=%h",
                     ovf, cout, sum, e[W+1], e[W], e[W-1:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        sbq.push_back(model(a, b, cin));
        last_acc = 1'b1;
      end
      hold_pending = out_valid && !out_ready;
      held_sum     = sum;
      held_cout    = cout;
      held_ovf     = ovf;
    end
    @(negedge clk);
  endtask

  vec_t vt[9];
  logic [W-1:0] bp_a[4];
  logic [W-1:0] bp_b[4];
  int idx;

  initial begin
    vt[0] = '{16'h1234, 16'h0FFF, 1'b1, 16'h2234, 1'b0, 1'b0};
    vt[1] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vt[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vt[7] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[8] = '{16'h00FF, 16'hFF00, 1'b1, 16'h0000, 1'b1, 1'b0};
    bp_a = '{16'h0001, 16'h1111, 16'h7FFF, 16'hFFFF};
    bp_b = '{16'h0002, 16'h2222, 16'h7FFF, 16'h0001};

    // Reset with stale valid operands presented.
    rst = 1'b1; in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("rst_nothing_emerges", {31'd0, out_valid}, 32'd0);

    // Directed vectors: accept at cycle 0, result valid at cycle 2 for one cycle.
    for (int i = 0; i < 9; i++) begin
      a = vt[i].a; b = vt[i].b; cin = vt[i].cin; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk("vec_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      tick();
      #1;
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_sum", i), {16'd0, sum}, {16'd0, vt[i].exp_sum});
      chk($sformatf("vec%0d_cout", i), {31'd0, cout}, {31'd0, vt[i].exp_cout});
      chk($sformatf("vec%0d_ovf", i), {31'd0, ovf}, {31'd0, vt[i].exp_ovf});
      tick();
      #1;
      chk($sformatf("vec%0d_one_cycle", i), {31'd0, out_valid}, 32'd0);
    end

    // Backpressure: four back-to-back operands, out_ready low for cycles 2..5.
    idx = 0;
    popped = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      out_ready = !(cyc >= 2 && cyc <= 5);
      in_valid  = (idx < 4);
      a   = (idx < 4) ? bp_a[idx] : '0;
      b   = (idx < 4) ? bp_b[idx] : '0;
      cin = 1'b0;
      #1;
      if (cyc >= 2 && cyc <= 5) begin
        chk($sformatf("bp_in_ready_c%0d", cyc), {31'd0, in_ready}, 32'd0);
        chk($sformatf("bp_out_valid_c%0d", cyc), {31'd0, out_valid}, 32'd1);
      end
      tick();
      if (last_acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_accepted", idx, 4);
    chk("bp_results", popped, 4);
    chk("bp_queue_empty", sbq.size(), 0);

    // Random streaming with a mid-stream reset.
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (i == 500) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      end else begin
        tick();
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && sbq.size() != 0; i++) tick();
    tick();
    chk("drain_queue_empty", sbq.size(), 0);
    #1;
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
